// File: rtl/queen_controller.sv
`default_nettype none
// ============================================================================
//  Module   : queen_controller
//  Purpose  : Control FSM for the stacked 8-queen solver datapath. Sequences
//             the backtracking search (push/scan/place/pop), reads the
//             solution out row 7 down to row 0 and owns the start/ready/done
//             handshake plus a sticky error flag.
//  Options  : ALL_SOLUTIONS_EN - keep searching after each solution, pulse
//             sol_valid per solution, count them in sol_count; done only
//             pulses once the search space is exhausted.
//  Revision : 1.0  initial release
// ============================================================================
module queen_controller #(
   parameter int OUT_HOLD       = 1,
   parameter int STACK_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       cout,
   input  logic       down_counter_zero,
   input  logic       row_zero,
   input  logic       last_column,
   input  logic       safe,
   input  logic       stack_ready,
   input  logic       underflow,
   output logic       enable_output,
   output logic       register_load,
   output logic       count,
   output logic       load_counter,
   output logic       push,
   output logic       pop,
   output logic       increament_row,
   output logic       increament_column,
   output logic       load_updated_position,
   output logic       reset_column,
   output logic       reset_to_seven,
`ifdef ALL_SOLUTIONS_EN
   output logic       sol_valid,
   output logic [6:0] sol_count,
`endif
   output logic       ready,
   output logic       done,
   output logic       error
);

   localparam logic [3:0] c_IDLE    = 4'd0;
   localparam logic [3:0] c_PUSH0   = 4'd1;
   localparam logic [3:0] c_WAITS   = 4'd2;
   localparam logic [3:0] c_SCAN0   = 4'd3;
   localparam logic [3:0] c_SCAN    = 4'd4;
   localparam logic [3:0] c_PLACE   = 4'd5;
   localparam logic [3:0] c_ADVROW  = 4'd6;
   localparam logic [3:0] c_NEXTCOL = 4'd7;
   localparam logic [3:0] c_POP     = 4'd8;
   localparam logic [3:0] c_POPW    = 4'd9;
   localparam logic [3:0] c_RDLOAD  = 4'd10;
   localparam logic [3:0] c_READ    = 4'd11;
   localparam logic [3:0] c_FIN     = 4'd12;
   localparam logic [3:0] c_EXHAUST = 4'd13;
   localparam logic [3:0] c_ERROR   = 4'd14;

   localparam int                 c_WAIT_W    = (STACK_WAIT_MAX > 1) ? $clog2(STACK_WAIT_MAX) : 1;
   localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(STACK_WAIT_MAX - 1);
   localparam logic [3:0]          c_HOLD_LAST = 4'(OUT_HOLD - 1);

   logic [3:0]          r_state;
   logic [3:0]          w_next;
   logic [c_WAIT_W-1:0] r_wait;
   logic [3:0]          r_hold;
   logic                r_repl;   // pop in flight belongs to a column replace (re-push after it)
   logic                r_error;
   logic                w_in_wait;
   logic                w_timeout;

   assign w_in_wait = (r_state == c_WAITS) || (r_state == c_POPW);
   assign w_timeout = w_in_wait && !stack_ready && (r_wait == c_WAIT_LAST);
   assign error     = r_error;

`ifdef ALL_SOLUTIONS_EN
   logic [6:0] r_sol_count;
   assign sol_count = r_sol_count;
`endif

   // State register, stack-wait timer, readout hold timer and sticky error
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= c_IDLE;
         r_wait  <= '0;
         r_hold  <= '0;
         r_repl  <= 1'b0;
         r_error <= 1'b0;
`ifdef ALL_SOLUTIONS_EN
         r_sol_count <= '0;
`endif
      end else begin
         r_state <= w_next;
         r_wait  <= (w_in_wait && !stack_ready) ? r_wait + 1'b1 : '0;
         r_hold  <= (r_state == c_READ && r_hold != c_HOLD_LAST) ? r_hold + 1'b1 : '0;
         if (r_state == c_NEXTCOL)
            r_repl <= !last_column;
         if (w_next == c_ERROR)
            r_error <= 1'b1;
         else if (r_state == c_IDLE && start)
            r_error <= 1'b0;
`ifdef ALL_SOLUTIONS_EN
         if (r_state == c_IDLE && start)
            r_sol_count <= '0;
         else if (r_state == c_FIN && r_sol_count != 7'd127)
            r_sol_count <= r_sol_count + 7'd1;
`endif
      end
   end

   // Next-state decode and per-state datapath strobes (all default low)
   always_comb begin
      w_next                = r_state;
      enable_output         = 1'b0;
      register_load         = 1'b0;
      count                 = 1'b0;
      load_counter          = 1'b0;
      push                  = 1'b0;
      pop                   = 1'b0;
      increament_row        = 1'b0;
      increament_column     = 1'b0;
      load_updated_position = 1'b0;
      reset_column          = 1'b0;
      reset_to_seven        = 1'b0;
      ready                 = 1'b0;
      done                  = 1'b0;
`ifdef ALL_SOLUTIONS_EN
      sol_valid             = 1'b0;
`endif
      case (r_state)
         c_IDLE: begin
            ready = 1'b1;
            if (start) w_next = c_PUSH0;
         end
         c_PUSH0: begin
            push   = 1'b1;
            w_next = c_WAITS;
         end
         c_WAITS: begin
            if (stack_ready)    w_next = c_SCAN0;
            else if (w_timeout) w_next = c_ERROR;
         end
         c_SCAN0: begin
            if (row_zero) w_next = c_PLACE;
            else begin
               load_counter = 1'b1;
               w_next       = c_SCAN;
            end
         end
         c_SCAN: begin
            if (!safe)                  w_next = c_NEXTCOL;
            else if (down_counter_zero) w_next = c_PLACE;
            else                        count  = 1'b1;
         end
         c_PLACE: begin
            register_load  = 1'b1;
            increament_row = 1'b1;
            if (cout) w_next = c_RDLOAD;
            else begin
               load_updated_position = 1'b1;
               reset_column          = 1'b1;
               w_next                = c_ADVROW;
            end
         end
         c_ADVROW: begin
            push   = 1'b1;
            w_next = c_WAITS;
         end
         c_NEXTCOL: begin
            if (last_column) begin
               w_next = row_zero ? c_EXHAUST : c_POP;
            end else begin
               load_updated_position = 1'b1;
               increament_column     = 1'b1;
               w_next                = c_POP;
            end
         end
         c_POP: begin
            pop    = 1'b1;
            w_next = c_POPW;
         end
         c_POPW: begin
            if (underflow)      w_next = c_ERROR;
            else if (stack_ready) w_next = r_repl ? c_ADVROW : c_NEXTCOL;
            else if (w_timeout) w_next = c_ERROR;
         end
         c_RDLOAD: begin
            load_counter   = 1'b1;
            reset_to_seven = 1'b1;
            w_next         = c_READ;
         end
         c_READ: begin
            enable_output = 1'b1;
            if (r_hold == c_HOLD_LAST) begin
               if (down_counter_zero) w_next = c_FIN;
               else                   count  = 1'b1;
            end
         end
         c_FIN: begin
`ifdef ALL_SOLUTIONS_EN
            sol_valid = 1'b1;
            w_next    = c_NEXTCOL;
`else
            done      = 1'b1;
            w_next    = c_IDLE;
`endif
         end
         c_EXHAUST: begin
            done   = 1'b1;
            w_next = c_IDLE;
         end
         c_ERROR: begin
            done   = 1'b1;
            w_next = c_IDLE;
         end
         default: w_next = c_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_queen_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_queen_controller
//  Purpose  : Directed bench for queen_controller. Two controllers (OUT_HOLD
//             1 and 3) each drive a small behavioural stack/counter datapath;
//             the bench checks readout words, handshake and error paths.
//  Revision : 1.0  initial release
// ============================================================================
module tb_queen_controller;

   logic clk;
   logic reset;
   logic start_v  [2];
   logic force_nr [2];   // hold stack_ready low on that instance

   logic       ready_v [2];
   logic       done_v  [2];
   logic       error_v [2];
   logic [10:0] strb_v [2];
   logic [7:0] ob_v    [2];
`ifdef ALL_SOLUTIONS_EN
   logic       solv_v  [2];
   logic [6:0] solc_v  [2];
`endif

   int n_vec = 0;
   int n_bad = 0;

   logic [7:0] exp_w [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int HOLD = (g == 0) ? 1 : 3;
      logic enable_output, register_load, count, load_counter, push, pop;
      logic increament_row, increament_column, load_updated_position;
      logic reset_column, reset_to_seven, ready, done, error;
      logic cout, down_counter_zero, row_zero, last_column, safe, stack_ready, underflow;
      logic [2:0] stk_col [8];
      logic [3:0] sp;
      logic [2:0] upd_col, cnt, top_row, top_col, oth_col;
      logic       uf;
      int         dr, dc;

      // Behavioural datapath: stack entry i holds the column of row i
      always_comb begin
         top_row = (sp == 4'd0) ? 3'd0 : 3'(sp - 4'd1);
         top_col = (sp == 4'd0) ? 3'd0 : stk_col[top_row];
         oth_col = stk_col[cnt];
         dr = int'(top_row) - int'(cnt);
         dc = int'(top_col) - int'(oth_col);
         if (dc < 0) dc = -dc;
         safe = (dc != 0) && (dr != dc);
      end
      assign row_zero          = (top_row == 3'd0);
      assign last_column       = (top_col == 3'd7);
      assign cout              = increament_row && (top_row == 3'd7);
      assign down_counter_zero = (cnt == 3'd0);
      assign stack_ready       = !force_nr[g];
      assign underflow         = uf;

      always_ff @(posedge clk) begin
         if (!reset) begin
            sp <= '0; upd_col <= '0; cnt <= '0; uf <= 1'b0;
         end else begin
            if (push) begin
               stk_col[sp[2:0]] <= upd_col;
               sp <= sp + 4'd1;
            end else if (pop) begin
               if (sp == 4'd0) uf <= 1'b1;
               else            sp <= sp - 4'd1;
            end
            if (load_updated_position)
               upd_col <= reset_column ? 3'd0 : top_col + {2'b00, increament_column};
            if (load_counter)
               cnt <= reset_to_seven ? 3'd7 : top_row - 3'd1;
            else if (count)
               cnt <= cnt - 3'd1;
         end
      end

      assign ready_v[g] = ready;
      assign done_v[g]  = done;
      assign error_v[g] = error;
      assign ob_v[g]    = enable_output ? (8'd1 << oth_col) : 8'd0;
      assign strb_v[g]  = {enable_output, register_load, count, load_counter, push, pop,
                           increament_row, increament_column, load_updated_position,
                           reset_column, reset_to_seven};

      queen_controller #(.OUT_HOLD(HOLD), .STACK_WAIT_MAX(15)) u_dut (
         .clk(clk), .reset(reset), .start(start_v[g]),
         .cout(cout), .down_counter_zero(down_counter_zero), .row_zero(row_zero),
         .last_column(last_column), .safe(safe), .stack_ready(stack_ready),
         .underflow(underflow),
         .enable_output(enable_output), .register_load(register_load), .count(count),
         .load_counter(load_counter), .push(push), .pop(pop),
         .increament_row(increament_row), .increament_column(increament_column),
         .load_updated_position(load_updated_position), .reset_column(reset_column),
         .reset_to_seven(reset_to_seven),
`ifdef ALL_SOLUTIONS_EN
         .sol_valid(solv_v[g]), .sol_count(solc_v[g]),
`endif
         .ready(ready), .done(done), .error(error)
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic pulse_start(input int idx);
      start_v[idx] = 1'b1;
      @(negedge clk);
      start_v[idx] = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Wait for readout on instance idx, then check every held word and the end pulse
   task automatic check_readout(input int idx, input int hold, input string tag);
      int k = 0;
      while (!strb_v[idx][10] && k < 30000) begin
         if (done_v[idx]) check({tag, "_early_done"}, 32'(done_v[idx]), 32'd0);
         @(negedge clk);
         k++;
      end
      check({tag, "_reach_read"}, 32'(k < 30000), 32'd1);
      for (int r = 0; r < 8; r++) begin
         for (int h = 0; h < hold; h++) begin
            check($sformatf("%s_row%0d_h%0d", tag, 7 - r, h), {23'd0, strb_v[idx][10], ob_v[idx]},
                  {23'd0, 1'b1, exp_w[r]});
            @(negedge clk);
         end
      end
      check({tag, "_read_end"}, 32'(strb_v[idx][10]), 32'd0);
`ifdef ALL_SOLUTIONS_EN
      check({tag, "_sol_valid"}, {30'd0, solv_v[idx], done_v[idx]}, 32'b10);
`else
      check({tag, "_fin"}, {30'd0, done_v[idx], error_v[idx]}, 32'b10);
      @(negedge clk);
      check({tag, "_idle"}, {29'd0, ready_v[idx], done_v[idx], error_v[idx]}, 32'b100);
`endif
   endtask

   initial begin
      exp_w[0] = 8'h08; exp_w[1] = 8'h02; exp_w[2] = 8'h40; exp_w[3] = 8'h04;
      exp_w[4] = 8'h20; exp_w[5] = 8'h80; exp_w[6] = 8'h10; exp_w[7] = 8'h01;
      reset = 1'b0;
      start_v[0] = 1'b1; start_v[1] = 1'b1;
      force_nr[0] = 1'b0; force_nr[1] = 1'b0;

      // Reset held with start high: idle, no strobes, no push
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("rst%0d_hs", c), {29'd0, ready_v[0], done_v[0], error_v[0]}, 32'b100);
         check($sformatf("rst%0d_strb", c), {21'd0, strb_v[0]}, 32'd0);
         check($sformatf("rst%0d_strb1", c), {21'd0, strb_v[1]}, 32'd0);
      end
      start_v[0] = 1'b0; start_v[1] = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("idle_after_rst", {29'd0, ready_v[0], done_v[0], error_v[0]}, 32'b100);

      // First solution at OUT_HOLD=1
      pulse_start(0);
      check("busy_after_start", 32'(ready_v[0]), 32'd0);
      check_readout(0, 1, "sol1");

      // OUT_HOLD=3: 24 readout cycles
      apply_reset();
      pulse_start(1);
      check_readout(1, 3, "hold3");

      // Stack never ready after the first push: timeout to ERROR
      apply_reset();
      pulse_start(0);
      check("first_push", 32'(strb_v[0][6]), 32'd1);
      force_nr[0] = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         check($sformatf("wait%0d", c), {28'd0, ready_v[0], done_v[0], error_v[0], strb_v[0][6]}, 32'b0000);
      end
      @(negedge clk);
      check("err_state", {29'd0, ready_v[0], done_v[0], error_v[0]}, 32'b011);
      @(negedge clk);
      check("err_idle", {29'd0, ready_v[0], done_v[0], error_v[0]}, 32'b101);
      check("err_idle_strb", {21'd0, strb_v[0]}, 32'd0);
      force_nr[0] = 1'b0;
      @(negedge clk);
      check("err_sticky", 32'(error_v[0]), 32'd1);
      pulse_start(0);
      check("err_cleared", 32'(error_v[0]), 32'd0);
      apply_reset();

      // Reset asserted while scanning aborts, restart finds the same solution
      pulse_start(0);
      begin
         int k = 0;
         while (!strb_v[0][7] && k < 200) begin @(negedge clk); k++; end
         check("reach_scan", 32'(k < 200), 32'd1);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("scan_rst_hs", {29'd0, ready_v[0], done_v[0], error_v[0]}, 32'b100);
      check("scan_rst_strb", {21'd0, strb_v[0]}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      pulse_start(0);
      check_readout(0, 1, "sol2");

`ifdef ALL_SOLUTIONS_EN
      // Full search: 92 solutions then a single done
      apply_reset();
      pulse_start(0);
      begin
         int n_sol = 0;
         int k = 0;
         while (!done_v[0] && k < 400000) begin
            if (solv_v[0]) n_sol++;
            @(negedge clk);
            k++;
         end
         check("all_finished", 32'(k < 400000), 32'd1);
         check("all_pulses", 32'(n_sol), 32'd92);
         check("all_count", 32'(solc_v[0]), 32'd92);
         check("all_error", 32'(error_v[0]), 32'd0);
         @(negedge clk);
         check("all_idle", {29'd0, ready_v[0], done_v[0], error_v[0]}, 32'b100);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
